// File: rtl/pad_frame_filt_pkg.sv
// -----------------------------------------------------------------------------
// pad_frame_filt_pkg
// Shared definitions for the generic pad frame with filtered inputs.
//   - bit positions of the fields inside a per-pad configuration word
//   - default configuration-word type for the default filter width
//   - helper that extracts the glitch-filter threshold from a config word
// -----------------------------------------------------------------------------
package pad_frame_filt_pkg;

   // Default geometry of a configuration word
   localparam int unsigned DEF_FILT_W = 4;
   localparam int unsigned DEF_CFG_W  = 2 + DEF_FILT_W;

   // Field positions inside a configuration word
   localparam int unsigned CFG_PULL_DIS_BIT = 0;
   localparam int unsigned CFG_FILT_EN_BIT  = 1;
   localparam int unsigned CFG_THR_LSB      = 2;

   typedef logic [DEF_CFG_W-1:0] pad_cfg_t;

   // Threshold field of a (zero-extended) config word, masked to filt_w bits.
   // Returned 32 bits wide so callers can compare against any counter width
   // without truncating.
   function automatic logic [31:0] cfg_thr(input logic [31:0] cfg,
                                           input int unsigned filt_w);
      logic [31:0] mask;
      mask = (32'd1 << filt_w) - 32'd1;
      return (cfg >> CFG_THR_LSB) & mask;
   endfunction

endpackage : pad_frame_filt_pkg

// File: rtl/pad_frame_filt_pad_in_filter.sv
// -----------------------------------------------------------------------------
// pad_in_filter
// Input path of one pad: synchroniser, programmable glitch filter and
// registered rise/fall event pulses.
//
// Ports
//   clk_i      block clock
//   rst_ni     asynchronous active-low reset
//   i_pad      raw, asynchronous pad input
//   i_filt_en  glitch filter enable (0 = bypass)
//   i_thr      filter threshold T, zero-extended to 32 bits
//   o_in       filtered, synchronised input (registered)
//   o_rise     one-cycle pulse in the first cycle o_in reads 1 after 0
//   o_fall     one-cycle pulse in the first cycle o_in reads 0 after 1
//   o_evt_nxt  combinational: a rise or fall pulse will be registered at
//              the next edge (used for the shared event flag)
// -----------------------------------------------------------------------------
module pad_in_filter
   import pad_frame_filt_pkg::*;
#(
   parameter int unsigned FILT_W      = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RST_VAL     = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        i_pad,
   input  logic        i_filt_en,
   input  logic [31:0] i_thr,
   output logic        o_in,
   output logic        o_rise,
   output logic        o_fall,
   output logic        o_evt_nxt
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [FILT_W-1:0]      r_cnt;
   logic                   r_in_q;
   logic                   r_rise;
   logic                   r_fall;

   logic                   w_s;
   logic                   w_cnt_ge;
   logic [FILT_W-1:0]      w_cnt_nxt;
   logic                   w_in_nxt;
   logic                   w_rise_nxt;
   logic                   w_fall_nxt;

   assign w_s = r_sync[SYNC_STAGES-1];

   // Compare in the 32-bit domain so the whole threshold is honoured; a
   // threshold lowered below the running count fires on the next edge.
   assign w_cnt_ge = ({{(32-FILT_W){1'b0}}, r_cnt} >= i_thr);

   // Synchroniser chain, shifting toward the MSB
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_sync <= {SYNC_STAGES{RST_VAL}};
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
      end
   end

   // Glitch filter next state: the count only advances while s disagrees
   // with the filtered state and restarts on any agreement (no decrement).
   always_comb begin
      w_in_nxt  = r_in_q;
      w_cnt_nxt = r_cnt;
      if (!i_filt_en) begin
         w_in_nxt  = w_s;
         w_cnt_nxt = {FILT_W{1'b0}};
      end else if (w_s == r_in_q) begin
         w_cnt_nxt = {FILT_W{1'b0}};
      end else if (w_cnt_ge) begin
         w_in_nxt  = w_s;
         w_cnt_nxt = {FILT_W{1'b0}};
      end else begin
         // threshold fits in FILT_W bits, so this never wraps
         w_cnt_nxt = r_cnt + {{(FILT_W-1){1'b0}}, 1'b1};
      end
   end

   // Edge pulses are derived from the next filtered value so they appear
   // in the same cycle as the new o_in value.
   assign w_rise_nxt = w_in_nxt & ~r_in_q;
   assign w_fall_nxt = ~w_in_nxt & r_in_q;
   assign o_evt_nxt  = w_rise_nxt | w_fall_nxt;

   // Filter state, counter and edge-pulse registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_in_q <= RST_VAL;
         r_cnt  <= {FILT_W{1'b0}};
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_in_q <= w_in_nxt;
         r_cnt  <= w_cnt_nxt;
         r_rise <= w_rise_nxt;
         r_fall <= w_fall_nxt;
      end
   end

   assign o_in   = r_in_q;
   assign o_rise = r_rise;
   assign o_fall = r_fall;

endmodule : pad_in_filter

// File: rtl/pad_frame_filt.sv
// -----------------------------------------------------------------------------
// pad_frame_filt
// Generic bidirectional pad frame front end. Drives the pad-cell controls
// combinationally from the peripheral/GPIO side and provides a synchronised,
// glitch-filtered input with rise/fall event pulses for every pad.
//
// Ports
//   clk_i      block clock
//   rst_ni     asynchronous active-low reset
//   pad_cfg_i  per-pad config: bit0 pull disable, bit1 filter enable,
//              bits[2+FILT_W-1:2] filter threshold T
//   oe_i       peripheral output enable, active-high
//   out_i      peripheral output data
//   in_o       filtered, synchronised pad input
//   rise_o     one-cycle pulse on a 0->1 transition of in_o
//   fall_o     one-cycle pulse on a 1->0 transition of in_o
//   evt_o      OR of all rise_o/fall_o, aligned with them
//   pad_in_i   raw O from the pad cells (asynchronous)
//   pad_oen_o  pad OEN, active-low output enable
//   pad_out_o  pad I, output data
//   pad_pen_o  pad PEN, pull enable
// -----------------------------------------------------------------------------
module pad_frame_filt
   import pad_frame_filt_pkg::*;
#(
   parameter int unsigned        N_PADS      = 48,
   parameter int unsigned        CFG_W       = 6,
   parameter int unsigned        FILT_W      = 4,
   parameter int unsigned        SYNC_STAGES = 2,
   parameter logic [N_PADS-1:0]  IN_RST_VAL  = '0
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [N_PADS-1:0][CFG_W-1:0]  pad_cfg_i,
   input  logic [N_PADS-1:0]             oe_i,
   input  logic [N_PADS-1:0]             out_i,
   output logic [N_PADS-1:0]             in_o,
   output logic [N_PADS-1:0]             rise_o,
   output logic [N_PADS-1:0]             fall_o,
   output logic                          evt_o,
   input  logic [N_PADS-1:0]             pad_in_i,
   output logic [N_PADS-1:0]             pad_oen_o,
   output logic [N_PADS-1:0]             pad_out_o,
   output logic [N_PADS-1:0]             pad_pen_o
);

   logic [N_PADS-1:0]        w_filt_en;
   logic [N_PADS-1:0][31:0]  w_thr;
   logic [N_PADS-1:0]        w_evt_nxt;
   logic                     r_evt;

   // Output path is purely combinational and independent of reset
   assign pad_oen_o = ~oe_i;
   assign pad_out_o = out_i;

   for (genvar p = 0; p < N_PADS; p++) begin : g_pad
      assign pad_pen_o[p] = ~pad_cfg_i[p][CFG_PULL_DIS_BIT];
      assign w_filt_en[p] = pad_cfg_i[p][CFG_FILT_EN_BIT];
      assign w_thr[p]     = cfg_thr(32'(pad_cfg_i[p]), FILT_W);

      pad_in_filter #(
         .FILT_W      (FILT_W),
         .SYNC_STAGES (SYNC_STAGES),
         .RST_VAL     (IN_RST_VAL[p])
      ) u_in_filt (
         .clk_i     (clk_i),
         .rst_ni    (rst_ni),
         .i_pad     (pad_in_i[p]),
         .i_filt_en (w_filt_en[p]),
         .i_thr     (w_thr[p]),
         .o_in      (in_o[p]),
         .o_rise    (rise_o[p]),
         .o_fall    (fall_o[p]),
         .o_evt_nxt (w_evt_nxt[p])
      );
   end

   // Shared event flag, registered from the same next-state terms as the
   // per-pad pulses so it lines up with them exactly.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_evt <= 1'b0;
      end else begin
         r_evt <= |w_evt_nxt;
      end
   end

   assign evt_o = r_evt;

endmodule : pad_frame_filt
